// File: rtl/rsa_block_feeder.sv
// Block feeder: queues message blocks, launches the RSA core one block at a time, returns results in order.
// Optional macro RSA_RANGE_CHECK_EN rejects blocks whose value is >= N without using the core.
module rsa_block_feeder #(
  parameter int WIDTH      = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] core_data,
  output logic             core_start,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             out_err,
  input  logic             out_ready,
  output logic [15:0]      blk_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, WAIT, EMIT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   fifo_mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;
  logic             push, pop;
  logic [WIDTH-1:0] blk_reg;
  logic             last_reg;
  logic             out_xfer;
  logic             cnt_clr;
  logic             reject;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign out_xfer   = out_valid && out_ready;

`ifdef RSA_RANGE_CHECK_EN
  assign reject = (fifo_mem[rd_ptr[AW-1:0]][WIDTH-1:0] >= N);
`else
  logic unused_n;
  assign unused_n = ^N;
  assign reject   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      blk_reg   <= '0;
      last_reg  <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      blk_count <= '0;
      cnt_clr   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr              <= rd_ptr + 1'b1;
        {last_reg, blk_reg} <= fifo_mem[rd_ptr[AW-1:0]];
        if (reject) begin
          out_data <= '0;
          out_err  <= 1'b1;
        end
      end
      if ((state == WAIT) && core_done) begin
        out_data <= core_result;
        out_err  <= 1'b0;
      end
      // Count clears one cycle after the final block of a message leaves.
      cnt_clr <= out_xfer && out_last;
      if (out_xfer)     blk_count <= blk_count + 1'b1;
      else if (cnt_clr) blk_count <= '0;
    end
  end

  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE:  if (!fifo_empty) state_nxt = reject ? EMIT : START;
      START: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT:  if (core_done) state_nxt = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_last  = out_valid && last_reg;
  assign core_data = blk_reg;

endmodule

// File: tb/tb_rsa_block_feeder.sv
// Bench for rsa_block_feeder: cube-mod-N core model with 5-cycle latency and an in-order reference queue.
module tb_rsa_block_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [5:0]  N = 6'd33;
  logic [5:0]  core_data;
  logic        core_start;
  logic        core_done;
  logic [5:0]  core_result;
  logic [5:0]  out_data;
  logic        out_valid, out_last, out_err;
  logic        out_ready = 1'b0;
  logic [15:0] blk_count;

  int errors = 0;
  int checks = 0;

  rsa_block_feeder #(.WIDTH(6), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .N(N),
    .core_data(core_data), .core_start(core_start),
    .core_done(core_done), .core_result(core_result),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_err(out_err),
    .out_ready(out_ready), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] cube_mod(input int d, input int n);
    if (n == 0) return 6'd0;
    return 6'((d * d * d) % n);
  endfunction

  function automatic bit rejected(input int d, input int n);
`ifdef RSA_RANGE_CHECK_EN
    return d >= n;
`else
    return 1'b0;
`endif
  endfunction

  // Core model
  bit         core_auto = 1'b1;
  logic       man_done = 1'b0;
  int         cd_cnt = 0;
  logic [5:0] cd_res = '0;
  always @(posedge clk) begin
    if (core_auto && core_start === 1'b1) begin
      cd_cnt <= 5;
      cd_res <= cube_mod(int'(core_data), int'(N));
    end else if (cd_cnt != 0) begin
      cd_cnt <= cd_cnt - 1;
    end
  end
  assign core_done   = (cd_cnt == 1) || man_done;
  assign core_result = cd_res;

  // Reference model state
  typedef struct packed { logic [5:0] d; logic l; } blk_t;
  blk_t q[$];
  int   e_cnt = 0;
  bit   clr_pend = 0;
  bit   in_core = 0;
  int   starts = 0;

  // Per-cycle observations and expectations
  logic        o_start, o_valid, o_inrdy, o_last, o_err;
  logic [5:0]  o_cdata, o_data;
  logic [15:0] o_cnt;
  bit          o_pushed, o_xfer, o_two_inflight;
  logic [5:0]  e_data, e_cdata;
  logic        e_last, e_err;
  int          exp_cnt_now;

  task automatic clear_model();
    q.delete();
    e_cnt = 0;
    clr_pend = 0;
    in_core = 0;
  endtask

  task automatic step(input bit v, input logic [5:0] d, input bit l, input bit ordy);
    blk_t b;
    @(negedge clk);
    o_start = core_start;  o_cdata = core_data;
    o_valid = out_valid;   o_data = out_data;
    o_last = out_last;     o_err = out_err;
    o_cnt = blk_count;     o_inrdy = in_ready;
    exp_cnt_now = e_cnt;
    if (clr_pend) begin
      e_cnt = 0;
      clr_pend = 0;
    end
    o_two_inflight = 0;
    e_cdata = ~core_data;
    if (core_start === 1'b1) begin
      starts++;
      o_two_inflight = in_core;
      in_core = 1;
      if (q.size() != 0) e_cdata = q[0].d;
    end
    in_valid = v;  in_data = d;  in_last = l;  out_ready = ordy;
    o_pushed = v && (in_ready === 1'b1);
    if (o_pushed) q.push_back('{d: d, l: l});
    o_xfer = (out_valid === 1'b1) && ordy;
    e_data = ~out_data; e_last = ~out_last; e_err = ~out_err;
    if (o_xfer && q.size() != 0) begin
      b = q.pop_front();
      e_err  = rejected(int'(b.d), int'(N));
      e_data = e_err ? 6'd0 : cube_mod(int'(b.d), int'(N));
      e_last = b.l;
      e_cnt++;
      clr_pend = b.l;
      in_core = 0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    checks++; if (out_data !== 6'd0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start: got %b want 0", core_start); end
    checks++; if (core_data !== 6'd0) begin errors++; $display("FAIL reset_core_data: got %0d want 0", core_data); end
    checks++; if (blk_count !== 16'd0) begin errors++; $display("FAIL reset_blk_count: got %0d want 0", blk_count); end
    reset = 1'b0;
    clear_model();
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    int k;
    N = 6'd33;
    step(1'b1, 6'd2, 1'b1, 1'b1);
    step(1'b0, 6'd0, 1'b0, 1'b1);
    checks++; if (o_start !== 1'b0) begin errors++; $display("FAIL single_early_start: got %b want 0", o_start); end
    step(1'b0, 6'd0, 1'b0, 1'b1);
    checks++; if (o_start !== 1'b1) begin errors++; $display("FAIL single_start_t2: got %b want 1", o_start); end
    checks++; if (o_cdata !== 6'd2) begin errors++; $display("FAIL single_core_data: got %0d want 2", o_cdata); end
    k = 0;
    do begin step(1'b0, 6'd0, 1'b0, 1'b1); k++; end while (!o_xfer && k < 40);
    checks++;
    if (!o_xfer) begin errors++; $display("FAIL single_timeout: got no output want one"); end
    else begin
      checks++; if (o_data !== 6'd8) begin errors++; $display("FAIL single_data: got %0d want 8", o_data); end
      checks++; if (o_last !== 1'b1) begin errors++; $display("FAIL single_last: got %b want 1", o_last); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", o_err); end
    end
    step(1'b0, 6'd0, 1'b0, 1'b1);
    checks++; if (o_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt_one: got %0d want 1", o_cnt); end
    step(1'b0, 6'd0, 1'b0, 1'b1);
    checks++; if (o_cnt !== 16'd0) begin errors++; $display("FAIL single_cnt_clear: got %0d want 0", o_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] vals [6] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6};
    logic [5:0] expv [6] = '{6'd1, 6'd8, 6'd27, 6'd31, 6'd26, 6'd18};
    int i = 0, got = 0, cyc = 0, s0;
    bit saw_full = 0;
    N = 6'd33;
    s0 = starts;
    while (got < 6 && cyc < 400) begin
      step(i < 6, vals[i % 6], i == 5, 1'b1);
      if (o_pushed) i++;
      if (o_inrdy === 1'b0) saw_full = 1;
      if (o_xfer) begin
        checks++; if (o_data !== expv[got]) begin errors++; $display("FAIL b2b_data[%0d]: got %0d want %0d", got, o_data, expv[got]); end
        checks++; if (o_last !== e_last) begin errors++; $display("FAIL b2b_last[%0d]: got %b want %b", got, o_last, e_last); end
        got++;
      end
      cyc++;
    end
    checks++; if (got != 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", got); end
    checks++; if (!saw_full) begin errors++; $display("FAIL b2b_in_ready_low: got never low want low when full"); end
    checks++; if (starts - s0 != 6) begin errors++; $display("FAIL b2b_starts: got %0d want 6", starts - s0); end
    step(1'b0, 6'd0, 1'b0, 1'b1);
    step(1'b0, 6'd0, 1'b0, 1'b1);
    checks++; if (o_cnt !== 16'd0) begin errors++; $display("FAIL b2b_cnt_clear: got %0d want 0", o_cnt); end
  endtask

  task automatic test_backpressure();
    logic [5:0] held;
    int k = 0, got = 0, s0;
    N = 6'd33;
    step(1'b1, 6'd5, 1'b0, 1'b0);
    step(1'b1, 6'd7, 1'b1, 1'b0);
    do begin step(1'b0, 6'd0, 1'b0, 1'b0); k++; end while (o_valid !== 1'b1 && k < 40);
    held = o_data;
    checks++; if (held !== 6'd26) begin errors++; $display("FAIL bp_first_data: got %0d want 26", held); end
    s0 = starts;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 6'd0, 1'b0, 1'b0);
      checks++; if (o_valid !== 1'b1 || o_data !== held) begin
        errors++; $display("FAIL bp_hold[%0d]: got valid=%b data=%0d want valid=1 data=%0d", c, o_valid, o_data, held);
      end
    end
    checks++; if (starts != s0) begin errors++; $display("FAIL bp_no_start: got %0d starts want 0", starts - s0); end
    k = 0;
    while (got < 2 && k < 60) begin
      step(1'b0, 6'd0, 1'b0, 1'b1);
      if (o_xfer) begin
        checks++; if (o_data !== e_data) begin errors++; $display("FAIL bp_data[%0d]: got %0d want %0d", got, o_data, e_data); end
        got++;
      end
      k++;
    end
    checks++; if (got != 2) begin errors++; $display("FAIL bp_drain: got %0d outputs want 2", got); end
  endtask

  task automatic test_range();
    int k = 0;
    bit saw_start = 0;
    logic [5:0] sdata = '0;
    N = 6'd33;
    step(1'b1, 6'd40, 1'b1, 1'b1);
    do begin
      step(1'b0, 6'd0, 1'b0, 1'b1);
      if (o_start === 1'b1) begin saw_start = 1; sdata = o_cdata; end
      k++;
    end while (!o_xfer && k < 40);
    checks++; if (!o_xfer) begin errors++; $display("FAIL range_timeout: got no output want one"); end
`ifdef RSA_RANGE_CHECK_EN
    checks++; if (saw_start) begin errors++; $display("FAIL range_start: got start want none"); end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL range_err: got %b want 1", o_err); end
    checks++; if (o_data !== 6'd0) begin errors++; $display("FAIL range_data: got %0d want 0", o_data); end
`else
    checks++; if (!saw_start || sdata !== 6'd40) begin errors++; $display("FAIL range_start: got start=%b data=%0d want start=1 data=40", saw_start, sdata); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL range_err: got %b want 0", o_err); end
    checks++; if (o_data !== 6'd13) begin errors++; $display("FAIL range_data: got %0d want 13", o_data); end
`endif
    step(1'b0, 6'd0, 1'b0, 1'b1);
    step(1'b0, 6'd0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int sent = 0, got = 0, cyc = 0, n = 40;
    logic [5:0] d;
    bit v, l;
    N = 6'($urandom_range(20, 63));
    d = 6'($urandom_range(0, 63));
    l = ($urandom_range(0, 3) == 0);
    while (got < n && cyc < 3000) begin
      v = (sent < n) && ($urandom_range(0, 9) < 7);
      step(v, d, l, $urandom_range(0, 9) < 7);
      if (o_pushed) begin
        sent++;
        d = 6'($urandom_range(0, 63));
        l = ($urandom_range(0, 3) == 0);
      end
      checks++; if (o_cnt !== 16'(exp_cnt_now)) begin errors++; $display("FAIL rand_cnt: got %0d want %0d", o_cnt, exp_cnt_now); end
      if (o_start === 1'b1) begin
        checks++; if (o_cdata !== e_cdata || o_two_inflight) begin
          errors++; $display("FAIL rand_start: got data=%0d overlap=%b want data=%0d overlap=0", o_cdata, o_two_inflight, e_cdata);
        end
      end
      if (o_xfer) begin
        checks++; if (o_data !== e_data || o_last !== e_last || o_err !== e_err) begin
          errors++; $display("FAIL rand_out[%0d]: got d=%0d l=%b e=%b want d=%0d l=%b e=%b", got, o_data, o_last, o_err, e_data, e_last, e_err);
        end
        got++;
      end
      cyc++;
    end
    checks++; if (got != n) begin errors++; $display("FAIL rand_drain: got %0d outputs want %0d", got, n); end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    core_auto = 0;
    N = 6'd33;
    step(1'b1, 6'd3, 1'b1, 1'b1);
    do begin step(1'b0, 6'd0, 1'b0, 1'b1); k++; end while (o_start !== 1'b1 && k < 10);
    checks++; if (o_start !== 1'b1) begin errors++; $display("FAIL rmid_start: got %b want 1", o_start); end
    step(1'b0, 6'd0, 1'b0, 1'b1);
    step(1'b0, 6'd0, 1'b0, 1'b1);
    @(negedge clk); reset = 1'b1; in_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    clear_model();
    @(negedge clk); man_done = 1'b1;
    @(negedge clk); man_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) man_done = 1'b1;
      step(1'b0, 6'd0, 1'b0, 1'b1);
      man_done = 1'b0;
      checks++; if (o_valid !== 1'b0 || o_inrdy !== 1'b1 || o_cnt !== 16'd0 || o_start !== 1'b0) begin
        errors++; $display("FAIL rmid_idle[%0d]: got valid=%b in_ready=%b cnt=%0d start=%b want 0/1/0/0", c, o_valid, o_inrdy, o_cnt, o_start);
      end
    end
    core_auto = 1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_range();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rsa_block_feeder.md
RSA_BLOCK_FEEDER -- requirements
Module: rsa_block_feeder

Interface
REQ-001 Parameter WIDTH, default 6: bit width of message blocks, modulus and results.
REQ-002 Parameter FIFO_DEPTH, default 4: input queue entries; power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  WIDTH  plaintext or ciphertext block from the upstream source.
REQ-006 in_valid  input  1  in_data and in_last are valid.
REQ-007 in_last  input  1  block is the final block of a message.
REQ-008 in_ready  output  1  feeder accepts a block; transfer occurs when in_valid and in_ready are both high.
REQ-009 N  input  WIDTH  modulus; held stable by the system while any block is in flight.
REQ-010 core_data  output  WIDTH  block presented to the downstream RSA exponentiation core.
REQ-011 core_start  output  1  one-cycle pulse launching the core on core_data.
REQ-012 core_done  input  1  core result is valid this cycle.
REQ-013 core_result  input  WIDTH  core result, sampled only when core_done is high.
REQ-014 out_data  output  WIDTH  result block.
REQ-015 out_valid, out_last, out_err  output  1 each  result valid; end of message; block was rejected by the range check.
REQ-016 out_ready  input  1  consumer accepts; transfer occurs when out_valid and out_ready are both high.
REQ-017 blk_count  output  16  result blocks transferred in the current message.

Function
REQ-018 The FIFO shall store {in_last, in_data}; in_ready shall equal NOT full; push and pop in the same cycle shall leave occupancy unchanged.
REQ-019 The FSM shall have states IDLE, START, WAIT and EMIT.
REQ-020 IDLE: when the FIFO is non-empty, pop the head into blk_reg/last_reg and go to START; if empty, stay in IDLE.
REQ-021 START: assert core_start for exactly one cycle, then go to WAIT.
REQ-022 core_data shall equal blk_reg, held stable from START until the core_done cycle.
REQ-023 WAIT: on core_done, latch core_result into out_data, set out_err=0 and go to EMIT; with no core_done, stay in WAIT indefinitely.
REQ-024 EMIT: out_valid=1 and out_last=last_reg; out_data, out_last and out_err shall be held stable until the out_ready cycle, then the FSM goes to IDLE.
REQ-025 core_done shall be ignored in IDLE, START and EMIT.
REQ-026 Latency, empty FIFO: in_data pushed at cycle t, popped at t+1, core_start at t+2; out_valid in the cycle after core_done.
REQ-027 Only one block shall be in the core at a time; results shall leave in input order.
REQ-028 blk_count shall increment on each output transfer and clear to 0 on the cycle after a transfer with out_last=1; it wraps at 16'hFFFF.

Reset
REQ-029 Reset shall empty the FIFO, enter IDLE, clear blk_count, and drive out_valid=0, out_last=0, out_err=0, out_data=0, core_start=0, core_data=0; in_ready=1 from the cycle after reset.
REQ-030 Reset mid-operation shall abandon any in-flight block with no output; a core_done arriving after reset shall be ignored.

Configuration
REQ-031 Macro RSA_RANGE_CHECK_EN defined: in IDLE, a popped block with value >= N shall skip START/WAIT and go straight to EMIT with out_data=0 and out_err=1; with N=0, every block is rejected.
REQ-032 RSA_RANGE_CHECK_EN undefined: no comparison logic, out_err is tied to 0, and every block is sent to the core.

Verification (core model: result = data^3 mod N, 5-cycle latency)
REQ-033 N=33; push 2 with in_last=1 at t -> core_start at t+2, core_data=2; out_data=8, out_last=1; blk_count 1 then 0.
REQ-034 N=33; push 1,2,3,4,5,6 back to back, out_ready=1 -> in_ready low while 4 entries are queued; outputs 1,8,27,31,26,18 in order with exactly six core_start pulses.
REQ-035 out_ready=0 for 10 cycles during EMIT -> out_valid and out_data held stable; no core_start until the transfer completes.
REQ-036 RSA_RANGE_CHECK_EN defined, N=33, push 40 -> no core_start; out_err=1, out_data=0; macro undefined -> core_start issued with core_data=40.
REQ-037 Reset asserted in WAIT, then core_done pulsed -> out_valid stays 0, in_ready=1, blk_count=0; core_done pulsed in IDLE -> no output.
